mbist_comparator: RTL and testbench
===================================

# mbist_comparator

Data comparator for the MBIST datapath. It compares the expected test pattern (`data_t`) against the word read back from the RAM under test (`ramout`). It provides combinational unsigned magnitude flags (`gt`, `eq`, `lt`) with zero latency. A clocked fail-tracking section reports per-compare mismatches, a sticky fail flag, a saturating mismatch count and first-failure capture for the MBIST controller.

## Interface
Parameters:
- `WIDTH`, 8, data word width in bits (≥1).
- `CNT_WIDTH`, 16, mismatch counter width in bits (≥1).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `data_t`  in  WIDTH  expected pattern.
- `ramout`  in  WIDTH  data read from RAM.
- `cmp_en`  in  1  qualifies the current cycle as a compare cycle.
- `clr`  in  1  synchronous clear of fail-tracking state.
- `gt`  out  1  `data_t > ramout`, unsigned, combinational.
- `eq`  out  1  `data_t == ramout`, combinational.
- `lt`  out  1  `data_t < ramout`, unsigned, combinational.
- `fail`  out  1  registered one-cycle mismatch pulse.
- `fail_sticky`  out  1  set on first qualified mismatch, held until `clr`/`rst`.
- `fail_count`  out  CNT_WIDTH  number of qualified mismatches, saturating.
- `first_exp`  out  WIDTH  `data_t` value at the first qualified mismatch.
- `first_act`  out  WIDTH  `ramout` value at the first qualified mismatch.

## Operation
- The magnitude flags are purely combinational from `data_t` and `ramout`. They are unaffected by `clk`, `rst`, `cmp_en` and `clr`.
  - Exactly one of `gt`/`eq`/`lt` is 1 for any pair of known inputs (one-hot).
  - The comparison is unsigned: `8'hFF` is greater than `8'h00`.
- A qualified mismatch is `cmp_en & ~eq` sampled at a rising edge.
- Register updates, evaluated in priority order at each rising edge:
  1. `rst`: all registered outputs go to 0.
  2. else `clr`: all registered outputs go to 0, and any compare in that cycle is discarded.
  3. else on a qualified mismatch:
     - `fail`=1;
     - `fail_count` increments, holding at all-ones once it reaches all-ones (no wrap);
     - if `fail_sticky` was 0, then `first_exp`←`data_t`, `first_act`←`ramout` and `fail_sticky`←1;
     - if `fail_sticky` was already 1, the capture registers hold.
  4. else: `fail`=0 and the other registers hold.
- `cmp_en`=0 never changes the count or capture state. It also deasserts `fail` on the next edge.
- Equal compares with `cmp_en`=1 produce no fail state.

## Timing
- `gt`/`eq`/`lt`: 0-cycle latency, combinational path only.
- `fail`: asserted for the cycle after the edge that samples a qualified mismatch. It is held for back-to-back mismatches.
- `fail_sticky`, `fail_count`, `first_exp`, `first_act`: valid the cycle after the sampling edge.
- Reset values: `fail`=0, `fail_sticky`=0, `fail_count`=0, `first_exp`=0, `first_act`=0. The magnitude flags track the inputs even during reset.
- Reset asserted mid-sequence clears all state at that edge, and any compare at that edge is lost.
- `clr` and `rst` together behave as `rst`.

## Test plan
- Magnitude flags, with a 10 time-unit settle after each input change, `cmp_en`=0:
  - 55/55 → eq=1, gt=0, lt=0;
  - AA/55 → gt=1, eq=0, lt=0;
  - 55/AA → lt=1, gt=0, eq=0;
  - 00/00 and FF/FF → eq=1, gt=0, lt=0;
  - FF/00 → gt=1, eq=0, lt=0;
  - 00/FF → lt=1, gt=0, eq=0;
  - 01/00 → gt=1, eq=0, lt=0.
- Reset: hold `rst`=1 for 2 edges with mismatching inputs and `cmp_en`=1 → all registered outputs 0; the flags still follow the inputs.
- Fail capture: `cmp_en`=1 on 55/55, then AA/55, then 0F/F0 on consecutive edges → `fail`=0,1,1; `fail_count`=2; `fail_sticky`=1; `first_exp`=AA; `first_act`=55.
- Qualification: mismatch 12/34 with `cmp_en`=0 for 3 edges → `fail`=0, `fail_count`=0, `fail_sticky`=0.
- Clear priority: `clr`=1 with a qualified mismatch on the same edge → all registered outputs 0. A mismatch on the next edge (for example 77/66) then captures `first_exp`=77, `first_act`=66 and `fail_count`=1.
- Saturation (`CNT_WIDTH`=3): 10 consecutive qualified mismatches → `fail_count` stops at 7, and `fail` stays 1 throughout.

Source files
------------

// File: rtl/mbist_comparator_if.sv
// Bus interface for mbist_comparator.
// slave  : comparator side (receives patterns/controls, drives flags and fail state)
// master : MBIST controller side
//   data_t, ramout    expected pattern / RAM read data
//   cmp_en, clr       compare qualifier / synchronous clear of fail tracking
//   gt, eq, lt        combinational unsigned magnitude flags
//   fail              registered one-cycle mismatch pulse
//   fail_sticky       set on first qualified mismatch
//   fail_count        saturating mismatch count
//   first_exp/act     pattern and read data captured at first mismatch
interface mbist_comparator_if #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
);
  logic [WIDTH-1:0]     data_t;
  logic [WIDTH-1:0]     ramout;
  logic                 cmp_en;
  logic                 clr;
  logic                 gt;
  logic                 eq;
  logic                 lt;
  logic                 fail;
  logic                 fail_sticky;
  logic [CNT_WIDTH-1:0] fail_count;
  logic [WIDTH-1:0]     first_exp;
  logic [WIDTH-1:0]     first_act;

  modport slave (
    input  data_t, ramout, cmp_en, clr,
    output gt, eq, lt, fail, fail_sticky, fail_count, first_exp, first_act
  );

  modport master (
    output data_t, ramout, cmp_en, clr,
    input  gt, eq, lt, fail, fail_sticky, fail_count, first_exp, first_act
  );
endinterface

// File: rtl/mbist_comparator.sv
// MBIST data comparator: zero-latency unsigned magnitude flags plus clocked
// fail tracking (mismatch pulse, sticky flag, saturating count, first-failure
// capture).
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  mbist_comparator_if.slave (see interface file for signal list)
// WIDTH/CNT_WIDTH must match the parameters of the connected interface.
module mbist_comparator #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned CNT_WIDTH = 16
) (
  input logic               clk,
  input logic               rst,
  mbist_comparator_if.slave bus
);

  logic                 w_gt;
  logic                 w_eq;
  logic                 w_lt;
  logic                 w_mismatch;

  logic                 r_fail;
  logic                 r_sticky;
  logic [CNT_WIDTH-1:0] r_count;
  logic [WIDTH-1:0]     r_first_exp;
  logic [WIDTH-1:0]     r_first_act;

  logic                 w_fail_nxt;
  logic                 w_sticky_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [WIDTH-1:0]     w_first_exp_nxt;
  logic [WIDTH-1:0]     w_first_act_nxt;

  // Magnitude flags: independent of clock, reset and controls.
  assign w_gt       = (bus.data_t > bus.ramout);
  assign w_eq       = (bus.data_t == bus.ramout);
  assign w_lt       = (bus.data_t < bus.ramout);
  assign w_mismatch = bus.cmp_en & ~w_eq;

  always_comb begin
    w_fail_nxt      = 1'b0;
    w_sticky_nxt    = r_sticky;
    w_count_nxt     = r_count;
    w_first_exp_nxt = r_first_exp;
    w_first_act_nxt = r_first_act;
    if (bus.clr) begin
      // Clear wins over a compare in the same cycle; that compare is dropped.
      w_sticky_nxt    = 1'b0;
      w_count_nxt     = '0;
      w_first_exp_nxt = '0;
      w_first_act_nxt = '0;
    end else if (w_mismatch) begin
      w_fail_nxt = 1'b1;
      if (r_count != {CNT_WIDTH{1'b1}}) begin
        w_count_nxt = r_count + 1'b1;
      end
      if (!r_sticky) begin
        w_sticky_nxt    = 1'b1;
        w_first_exp_nxt = bus.data_t;
        w_first_act_nxt = bus.ramout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fail      <= 1'b0;
      r_sticky    <= 1'b0;
      r_count     <= '0;
      r_first_exp <= '0;
      r_first_act <= '0;
    end else begin
      r_fail      <= w_fail_nxt;
      r_sticky    <= w_sticky_nxt;
      r_count     <= w_count_nxt;
      r_first_exp <= w_first_exp_nxt;
      r_first_act <= w_first_act_nxt;
    end
  end

  assign bus.gt          = w_gt;
  assign bus.eq          = w_eq;
  assign bus.lt          = w_lt;
  assign bus.fail        = r_fail;
  assign bus.fail_sticky = r_sticky;
  assign bus.fail_count  = r_count;
  assign bus.first_exp   = r_first_exp;
  assign bus.first_act   = r_first_act;

endmodule

// File: tb/tb_mbist_comparator.sv
// Self-checking bench for mbist_comparator. Two instances share the same
// stimulus: one with the default 16-bit counter and one with a 3-bit counter
// to exercise saturation. A behavioural model tracks expected state.
module tb_mbist_comparator;

  logic       clk;
  logic       rst;
  logic [7:0] s_data;
  logic [7:0] s_ram;
  logic       s_cmp_en;
  logic       s_clr;

  int n_assert = 0;
  int n_fail   = 0;

  mbist_comparator_if #(.WIDTH(8), .CNT_WIDTH(16)) bus_a ();
  mbist_comparator_if #(.WIDTH(8), .CNT_WIDTH(3))  bus_b ();

  assign bus_a.data_t = s_data;
  assign bus_a.ramout = s_ram;
  assign bus_a.cmp_en = s_cmp_en;
  assign bus_a.clr    = s_clr;
  assign bus_b.data_t = s_data;
  assign bus_b.ramout = s_ram;
  assign bus_b.cmp_en = s_cmp_en;
  assign bus_b.clr    = s_clr;

  mbist_comparator #(.WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  mbist_comparator #(.WIDTH(8), .CNT_WIDTH(3)) u_sat (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: state after each rising edge, from the sampled inputs.
  int unsigned m_fail   = 0;
  int unsigned m_sticky = 0;
  int unsigned m_cnt16  = 0;
  int unsigned m_cnt3   = 0;
  int unsigned m_exp    = 0;
  int unsigned m_act    = 0;

  always @(posedge clk) begin
    if (rst || s_clr) begin
      m_fail = 0; m_sticky = 0; m_cnt16 = 0; m_cnt3 = 0; m_exp = 0; m_act = 0;
    end else if (s_cmp_en && (s_data != s_ram)) begin
      m_fail = 1;
      if (m_cnt16 < 65535) m_cnt16 = m_cnt16 + 1;
      if (m_cnt3 < 7) m_cnt3 = m_cnt3 + 1;
      if (m_sticky == 0) begin
        m_sticky = 1;
        m_exp    = s_data;
        m_act    = s_ram;
      end
    end else begin
      m_fail = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    int unsigned d;
    int unsigned r;
    d = s_data;
    r = s_ram;
    check({tag, ".gt"}, 32'(bus_a.gt), (d > r) ? 32'd1 : 32'd0);
    check({tag, ".eq"}, 32'(bus_a.eq), (d == r) ? 32'd1 : 32'd0);
    check({tag, ".lt"}, 32'(bus_a.lt), (d < r) ? 32'd1 : 32'd0);
  endtask

  task automatic check_regs(input string tag);
    check({tag, ".fail"},    32'(bus_a.fail),        m_fail);
    check({tag, ".sticky"},  32'(bus_a.fail_sticky), m_sticky);
    check({tag, ".count"},   32'(bus_a.fail_count),  m_cnt16);
    check({tag, ".exp"},     32'(bus_a.first_exp),   m_exp);
    check({tag, ".act"},     32'(bus_a.first_act),   m_act);
    check({tag, ".b_fail"},  32'(bus_b.fail),        m_fail);
    check({tag, ".b_count"}, 32'(bus_b.fail_count),  m_cnt3);
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [7:0] d, input logic [7:0] r, input logic en);
    s_data   = d;
    s_ram    = r;
    s_cmp_en = en;
  endtask

  logic [7:0] flag_d [9] = '{8'h55, 8'hAA, 8'h55, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h01, 8'h80};
  logic [7:0] flag_r [9] = '{8'h55, 8'h55, 8'hAA, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h7F};

  initial begin
    rst   = 1'b1;
    s_clr = 1'b0;
    set_in(8'hAA, 8'h55, 1'b1);

    // Reset held for two edges with a qualified mismatch present.
    step();
    step();
    check_regs("reset");
    check_flags("reset_flags");
    check("reset.fail0", 32'(bus_a.fail), 32'd0);

    // Magnitude flags with compare disabled.
    rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      set_in(flag_d[i], flag_r[i], 1'b0);
      #10;
      check_flags($sformatf("flags%0d", i));
    end
    check_regs("flags_regs");

    // Fail capture over three consecutive edges.
    set_in(8'h55, 8'h55, 1'b1);
    step();
    check_regs("cap0");
    set_in(8'hAA, 8'h55, 1'b1);
    step();
    check_regs("cap1");
    set_in(8'h0F, 8'hF0, 1'b1);
    step();
    check_regs("cap2");
    check("cap.count2", 32'(bus_a.fail_count), 32'd2);
    check("cap.expAA",  32'(bus_a.first_exp),  32'h0000_00AA);
    check("cap.act55",  32'(bus_a.first_act),  32'h0000_0055);

    // Unqualified mismatches after a clear.
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    set_in(8'h12, 8'h34, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_regs($sformatf("qual%0d", i));
    end

    // Clear priority over a same-edge mismatch, then a fresh capture.
    set_in(8'h99, 8'h11, 1'b1);
    step();
    s_clr = 1'b1;
    step();
    check_regs("clr");
    check("clr.sticky0", 32'(bus_a.fail_sticky), 32'd0);
    s_clr = 1'b0;
    set_in(8'h77, 8'h66, 1'b1);
    step();
    check_regs("post_clr");
    check("post_clr.exp77", 32'(bus_a.first_exp), 32'h0000_0077);

    // Saturation of the 3-bit counter over 10 consecutive mismatches.
    s_clr = 1'b1;
    step();
    s_clr = 1'b0;
    for (int i = 0; i < 10; i++) begin
      set_in(8'(i + 1), 8'(i + 100), 1'b1);
      step();
      check_regs($sformatf("sat%0d", i));
    end
    check("sat.b_count7", 32'(bus_b.fail_count), 32'd7);

    // Mid-sequence reset drops the compare at that edge.
    rst = 1'b1;
    set_in(8'h3C, 8'hC3, 1'b1);
    step();
    check_regs("mid_rst");
    rst = 1'b0;

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      rst   = ($urandom_range(0, 40) == 0);
      s_clr = ($urandom_range(0, 20) == 0);
      set_in(d, ($urandom_range(0, 2) == 0) ? d : 8'($urandom), 1'($urandom_range(0, 1)));
      step();
      check_regs($sformatf("rnd%0d", i));
      check_flags($sformatf("rnd%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
